// File: rtl/async_fifo_pkg.sv
// Shared async-FIFO helpers: pointer width rule and Gray/binary conversion.
// Functions work at MAX_PTR_WIDTH bits; callers zero-extend in and truncate out.
package async_fifo_pkg;

  localparam int MAX_PTR_WIDTH = 32;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] gray);
    logic [MAX_PTR_WIDTH-1:0] bin;
    bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO: request, remote read pointer and status.
// master drives requests (upstream / bench), slave is the pointer controller.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  w_inc_i;
  logic [ADDR_WIDTH:0]   r_ptr_gray_i;
  logic                  w_clk_en_o;
  logic                  w_full_o;
  logic [ADDR_WIDTH-1:0] w_addr_o;
  logic [ADDR_WIDTH:0]   w_ptr_gray_o;
  logic                  w_almost_full_o;
  logic [ADDR_WIDTH:0]   w_level_o;

  modport master (
    output w_inc_i, r_ptr_gray_i,
    input  w_clk_en_o, w_full_o, w_addr_o, w_ptr_gray_o, w_almost_full_o, w_level_o
  );

  modport slave (
    input  w_inc_i, r_ptr_gray_i,
    output w_clk_en_o, w_full_o, w_addr_o, w_ptr_gray_o, w_almost_full_o, w_level_o
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus; two destination-clock cycles of latency.
// Only safe for buses where at most one bit changes between source updates.
module sync_2ff #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/full controller: binary address + gated enable for the memory,
// Gray pointer out to the read side, registered full/almost-full/level from the synced read pointer.
module fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int AF_MARGIN  = 4
) (
  input logic              clk_w_i,
  input logic              rst_w_ni,
  fifo_wptr_full_if.slave  bus
);

  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);
  // Full pattern: write pointer exactly one lap ahead, i.e. top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_FLIP = {2'b11, {(PW-2){1'b0}}};

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] rq2;
  logic          full_q;
  logic          af_q;
  logic [PW-1:0] level_q;

  logic          w_clk_en;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          af_next;

  sync_2ff #(
    .WIDTH (PW)
  ) u_rptr_sync (
    .clk   (clk_w_i),
    .rst_n (rst_w_ni),
    .d     (bus.r_ptr_gray_i),
    .q     (rq2)
  );

  always_comb begin
    w_clk_en   = bus.w_inc_i & ~full_q;
    wbin_next  = wbin + PW'(w_clk_en);
    wgray_next = PW'(bin2gray(MAX_PTR_WIDTH'(wbin_next)));
    rbin_sync  = PW'(gray2bin(MAX_PTR_WIDTH'(rq2)));
    level_next = wbin_next - rbin_sync;
    full_next  = (wgray_next == (rq2 ^ FULL_FLIP));
    af_next    = (level_next >= AF_THRESH);
  end

  always_ff @(posedge clk_w_i or negedge rst_w_ni) begin
    if (!rst_w_ni) begin
      wbin    <= '0;
      wgray   <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
    end else begin
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      full_q  <= full_next;
      af_q    <= af_next;
      level_q <= level_next;
    end
  end

  assign bus.w_clk_en_o      = w_clk_en;
  assign bus.w_full_o        = full_q;
  assign bus.w_addr_o        = wbin[ADDR_WIDTH-1:0];
  assign bus.w_ptr_gray_o    = wgray;
  assign bus.w_almost_full_o = af_q;
  assign bus.w_level_o       = level_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full: a spec-level model pushes expected post-edge outputs
// to a scoreboard queue as each cycle is driven; they are popped and compared after the edge.
module tb_fifo_wptr_full;
  import async_fifo_pkg::*;

  localparam int AW    = 8;
  localparam int AF    = 4;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW:0]   gray;
    logic          full;
    logic          af;
    logic [AW:0]   level;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [AW:0] m_wbin, m_rq1, m_rq2;
  logic        m_full;

  fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wptr_full #(
    .ADDR_WIDTH (AW),
    .AF_MARGIN  (AF)
  ) dut (
    .clk_w_i  (clk),
    .rst_w_ni (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_clear();
    m_wbin = '0; m_rq1 = '0; m_rq2 = '0; m_full = 1'b0;
    sb.delete();
  endtask

  // Called just after a rising edge: drive, predict, clock, compare.
  task automatic step(input logic inc, input logic [AW:0] rg);
    exp_t        e, got;
    logic        en;
    logic [AW:0] nb, rb;
    bus.w_inc_i      = inc;
    bus.r_ptr_gray_i = rg;
    #1;
    en = inc & ~m_full;
    check("clk_en", {31'd0, bus.w_clk_en_o}, {31'd0, en});
    nb      = m_wbin + (AW+1)'(en);
    rb      = (AW+1)'(gray2bin(32'(m_rq2)));
    e.addr  = nb[AW-1:0];
    e.gray  = to_gray(nb);
    e.full  = (e.gray == (m_rq2 ^ {2'b11, {(AW-1){1'b0}}}));
    e.level = nb - rb;
    e.af    = (e.level >= (AW+1)'(DEPTH - AF));
    sb.push_back(e);
    m_wbin = nb; m_rq2 = m_rq1; m_rq1 = rg; m_full = e.full;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("addr",  32'(bus.w_addr_o),        32'(got.addr));
      check("gray",  32'(bus.w_ptr_gray_o),    32'(got.gray));
      check("full",  32'(bus.w_full_o),        32'(got.full));
      check("afull", 32'(bus.w_almost_full_o), 32'(got.af));
      check("level", 32'(bus.w_level_o),       32'(got.level));
    end
  endtask

  // Asserts reset between edges and checks outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    bus.w_inc_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check({tag, "_full"},  32'(bus.w_full_o),        0);
    check({tag, "_afull"}, 32'(bus.w_almost_full_o), 0);
    check({tag, "_level"}, 32'(bus.w_level_o),       0);
    check({tag, "_addr"},  32'(bus.w_addr_o),        0);
    check({tag, "_gray"},  32'(bus.w_ptr_gray_o),    0);
    check({tag, "_en"},    32'(bus.w_clk_en_o),      1);
    bus.w_inc_i = 1'b0;
    bus.r_ptr_gray_i = '0;
    model_clear();
    @(posedge clk);
    #1;
    check({tag, "_full_held"}, 32'(bus.w_full_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          total;
    logic [AW:0] rbv, prev_gray;
    logic        seen_wrap, any_full;

    bus.w_inc_i = 1'b0;
    bus.r_ptr_gray_i = '0;
    model_clear();
    #2;
    async_reset("rst0");

    // Fill from empty with the read pointer parked at 0.
    for (int i = 1; i <= 260; i++) begin
      check("fill_addr_pre", 32'(bus.w_addr_o), (i <= DEPTH) ? 32'(i - 1) : 32'd0);
      step(1'b1, '0);
      check("fill_afull", 32'(bus.w_almost_full_o), (i >= 252) ? 32'd1 : 32'd0);
      check("fill_full",  32'(bus.w_full_o),        (i >= 256) ? 32'd1 : 32'd0);
    end
    check("fill_level", 32'(bus.w_level_o), 256);

    // Read side advances by one; full should drop only after the third edge.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 9'd1);
      check("drain_full", 32'(bus.w_full_o), (k < 2) ? 32'd1 : 32'd0);
    end
    check("drain_level", 32'(bus.w_level_o), 255);
    check("drain_addr_pre", 32'(bus.w_addr_o), 0);
    step(1'b1, 9'd1);
    check("drain_addr_post", 32'(bus.w_addr_o), 1);

    async_reset("rst_full");

    // Simultaneous write and read each cycle settles at a constant level.
    for (int i = 0; i < 98; i++) step(1'b1, '0);
    check("sim_pre_level", 32'(bus.w_level_o), 98);
    for (int j = 1; j <= 20; j++) begin
      step(1'b1, to_gray(9'(j)));
      if (j >= 3) begin
        check("sim_level", 32'(bus.w_level_o), 100);
        check("sim_flags", {30'd0, bus.w_full_o, bus.w_almost_full_o}, 0);
      end
    end

    async_reset("rst_sim");

    // Wrap: read pointer trails the write pointer by 10 across two full laps.
    total = 0; prev_gray = '0; seen_wrap = 1'b0; any_full = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      rbv = (total >= 10) ? 9'(total - 10) : 9'd0;
      step(1'b1, to_gray(rbv));
      total++;
      if (bus.w_ptr_gray_o !== prev_gray)
        check("wrap_hamming", $countones(bus.w_ptr_gray_o ^ prev_gray), 1);
      if (prev_gray == 9'h100 && bus.w_ptr_gray_o == 9'h000) seen_wrap = 1'b1;
      if (bus.w_full_o) any_full = 1'b1;
      prev_gray = bus.w_ptr_gray_o;
    end
    check("wrap_seen", 32'(seen_wrap), 1);
    check("wrap_never_full", 32'(any_full), 0);

    async_reset("rst_wrap");

    // Reset mid-fill restarts the pointer from zero.
    for (int i = 0; i < 200; i++) step(1'b1, '0);
    check("mid_level", 32'(bus.w_level_o), 200);
    async_reset("rst_mid");
    check("post_rst_addr_pre", 32'(bus.w_addr_o), 0);
    step(1'b1, '0);
    check("post_rst_addr", 32'(bus.w_addr_o), 1);
    check("post_rst_level", 32'(bus.w_level_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
